// File: rtl/pdma_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pdma_fifo_pkg
//  Description : Shared widths, default thresholds and occupancy-update
//                encoding for the PDMA FIFO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pdma_fifo_pkg;

   localparam int MEM_BYTES        = 256;
   localparam int WR_AW            = 7;
   localparam int RD_AW            = 8;
   localparam int CNT_W            = 9;
   localparam int DEF_REQ_THRESH   = 16;
   localparam int DEF_AFULL_THRESH = 224;

   typedef enum logic [1:0] {
      OCC_NONE = 2'd0,
      OCC_WR   = 2'd1,
      OCC_RD   = 2'd2,
      OCC_BOTH = 2'd3
   } occ_upd_e;

   function automatic occ_upd_e occ_encode(input logic wr, input logic rd);
      return occ_upd_e'({rd, wr});
   endfunction

endpackage
`default_nettype wire

// File: rtl/pdma_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pdma_fifo_ctrl_if
//  Description : Producer/consumer handshake, status and USRAM port bundle
//                for the PDMA FIFO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pdma_fifo_ctrl_if;
   import pdma_fifo_pkg::*;

   logic             clr;
   logic             wr_en;
   logic [15:0]      wr_data;
   logic             rd_en;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             afull;
   logic             dma_req;
   logic             wr_ovf;
   logic             rd_udf;
   logic [15:0]      c_din;
   logic [WR_AW-1:0] c_addr;
   logic             c_wen;
   logic             c_blk;
   logic [RD_AW-1:0] a_addr;
   logic             a_addr_en;
   logic             a_blk;
   logic             a_addr_srst_n;
   logic [7:0]       a_dout;

   modport slave (
      input  clr, wr_en, wr_data, rd_en, a_dout,
      output rd_data, rd_valid, count, empty, full, afull, dma_req,
             wr_ovf, rd_udf, c_din, c_addr, c_wen, c_blk,
             a_addr, a_addr_en, a_blk, a_addr_srst_n
   );

   modport master (
      output clr, wr_en, wr_data, rd_en, a_dout,
      input  rd_data, rd_valid, count, empty, full, afull, dma_req,
             wr_ovf, rd_udf, c_din, c_addr, c_wen, c_blk,
             a_addr, a_addr_en, a_blk, a_addr_srst_n
   );

endinterface
`default_nettype wire

// File: rtl/pdma_fifo_level.sv
`default_nettype none
// ============================================================================
//  Module      : pdma_fifo_level
//  Description : Byte-occupancy register and the threshold flags derived
//                from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdma_fifo_level
   import pdma_fifo_pkg::*;
#(
   parameter int DEPTH_BYTES  = MEM_BYTES,
   parameter int REQ_THRESH   = DEF_REQ_THRESH,
   parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_clr,
   input  wire occ_upd_e         i_upd,
   output logic [CNT_W-1:0]      o_count,
   output logic                  o_empty,
   output logic                  o_full,
   output logic                  o_afull,
   output logic                  o_dma_req
);

   localparam logic [CNT_W-1:0] c_full_lim   = CNT_W'(DEPTH_BYTES - 2);
   localparam logic [CNT_W-1:0] c_req_thresh = CNT_W'(REQ_THRESH);
   localparam logic [CNT_W-1:0] c_afull_thr  = CNT_W'(AFULL_THRESH);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;

   // Upstream gating guarantees writes only below full and reads only above
   // empty, so these steps stay within 0..DEPTH_BYTES.
   always_comb begin
      w_count_nxt = r_count;
      case (i_upd)
         OCC_WR:   w_count_nxt = r_count + CNT_W'(2);
         OCC_RD:   w_count_nxt = r_count - CNT_W'(1);
         OCC_BOTH: w_count_nxt = r_count + CNT_W'(1);
         default:  w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign o_count   = r_count;
   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count > c_full_lim);
   assign o_afull   = (r_count >= c_afull_thr);
   assign o_dma_req = (r_count >= c_req_thresh);

endmodule
`default_nettype wire

// File: rtl/pdma_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pdma_fifo_ctrl
//  Description : Pointer, flag and read-capture controller for the
//                128x16-write / 256x8-read USRAM FIFO feeding the PDMA.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdma_fifo_ctrl
   import pdma_fifo_pkg::*;
#(
   parameter int DEPTH_BYTES  = MEM_BYTES,
   parameter int REQ_THRESH   = DEF_REQ_THRESH,
   parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
   input  wire logic       clk,
   input  wire logic       rst,
   pdma_fifo_ctrl_if.slave bus
);

   logic [WR_AW-1:0] r_wr_ptr;
   logic [RD_AW-1:0] r_rd_ptr;
   logic             r_wr_ovf;
   logic             r_rd_udf;
   logic             r_rd_pend;
   logic             r_rd_valid;
   logic [7:0]       r_rd_data;

   logic             w_full;
   logic             w_empty;
   logic             w_wr_acc;
   logic             w_rd_acc;
   occ_upd_e         w_upd;

   // Flush wins over both requests in the same cycle.
   assign w_wr_acc = bus.wr_en & ~w_full  & ~bus.clr;
   assign w_rd_acc = bus.rd_en & ~w_empty & ~bus.clr;
   assign w_upd    = occ_encode(w_wr_acc, w_rd_acc);

   pdma_fifo_level #(
      .DEPTH_BYTES  (DEPTH_BYTES),
      .REQ_THRESH   (REQ_THRESH),
      .AFULL_THRESH (AFULL_THRESH)
   ) u_level (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (bus.clr),
      .i_upd     (w_upd),
      .o_count   (bus.count),
      .o_empty   (w_empty),
      .o_full    (w_full),
      .o_afull   (bus.afull),
      .o_dma_req (bus.dma_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_wr_ovf <= 1'b0;
         r_rd_udf <= 1'b0;
      end else if (bus.clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_wr_ovf <= 1'b0;
         r_rd_udf <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + WR_AW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + RD_AW'(1);
         if (bus.wr_en && w_full)  r_wr_ovf <= 1'b1;
         if (bus.rd_en && w_empty) r_rd_udf <= 1'b1;
      end
   end

   // The memory registers A_ADDR on the accepting edge and presents the byte
   // during the following cycle; it is captured one edge later. A flush does
   // not cancel a capture already under way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_pend  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= 8'h00;
      end else begin
         r_rd_pend  <= w_rd_acc;
         r_rd_valid <= r_rd_pend;
         if (r_rd_pend) r_rd_data <= bus.a_dout;
      end
   end

   assign bus.empty         = w_empty;
   assign bus.full          = w_full;
   assign bus.wr_ovf        = r_wr_ovf;
   assign bus.rd_udf        = r_rd_udf;
   assign bus.rd_valid      = r_rd_valid;
   assign bus.rd_data       = r_rd_data;
   assign bus.c_din         = bus.wr_data;
   assign bus.c_addr        = r_wr_ptr;
   assign bus.c_wen         = w_wr_acc;
   assign bus.c_blk         = 1'b1;
   assign bus.a_addr        = r_rd_ptr;
   assign bus.a_addr_en     = w_rd_acc;
   assign bus.a_blk         = 1'b1;
   assign bus.a_addr_srst_n = 1'b1;

endmodule
`default_nettype wire
